// File: rtl/ring_phase_tracker_pkg.sv
// Shared types and helpers for the ring phase tracker: FSM state encoding plus
// one-hot test, binary encode and single-step left rotate on a padded vector.
package ring_phase_tracker_pkg;

  localparam int RING_MAX_W = 32;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } ring_state_e;

  function automatic logic ring_is_onehot(input logic [RING_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic int unsigned ring_encode(input logic [RING_MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < RING_MAX_W; i++) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

  // Rotate left by one within the low w bits; bits at and above w are forced to zero.
  function automatic logic [RING_MAX_W-1:0] ring_rotl1(input logic [RING_MAX_W-1:0] v,
                                                       input int unsigned w);
    logic [RING_MAX_W-1:0] mask;
    mask = (RING_MAX_W'(1) << w) - 1'b1;
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/ring_phase_tracker_encoder.sv
// Combinational one-hot legality check and binary encode of the sampled ring vector.
// The index reads 0 whenever the vector is not one-hot.
module ring_onehot_encoder
  import ring_phase_tracker_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] vec,
  output logic             onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    onehot = ring_is_onehot(RING_MAX_W'(vec));
    idx    = '0;
    if (onehot) idx = IDX_W'(ring_encode(RING_MAX_W'(vec)));
  end

endmodule

// File: rtl/ring_phase_tracker.sv
// Tracks a one-hot ring counter: locks after LOCK_CYCLES legal advances, counts rotations
// and flags sequencing errors. Define RING_TRACK_ERRCNT_EN to add the saturating err_count port.
module ring_phase_tracker
  import ring_phase_tracker_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ROT_CNT_W   = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         phase_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] phase_idx,
  output logic                     onehot_ok,
  output logic                     locked,
  output logic                     wrap_pulse,
  output logic [ROT_CNT_W-1:0]     rot_count,
  output logic                     step_err,
  output logic                     err_sticky
`ifdef RING_TRACK_ERRCNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam int IDX_W    = $clog2(WIDTH);
  localparam int STREAK_W = $clog2(LOCK_CYCLES + 1);

  ring_state_e         state;
  logic [WIDTH-1:0]    ref_q;
  logic [STREAK_W-1:0] streak;

  logic                s_onehot;
  logic [IDX_W-1:0]    s_idx;
  logic [WIDTH-1:0]    ref_rot;
  logic                is_adv;
  logic                is_hold;
  logic                legal;
  logic                step_ev;
  logic                wrap_ev;

  ring_onehot_encoder #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_encoder (
    .vec   (phase_in),
    .onehot(s_onehot),
    .idx   (s_idx)
  );

  // A cleared ref rotates to zero, so it can never match a one-hot sample.
  always_comb begin
    ref_rot = WIDTH'(ring_rotl1(RING_MAX_W'(ref_q), WIDTH));
    is_adv  = s_onehot && (phase_in == ref_rot);
    is_hold = s_onehot && (phase_in == ref_q);
    legal   = is_adv || is_hold;
    step_ev = en && (state == LOCKED) && !legal;
    wrap_ev = en && (state == LOCKED) && is_adv && ref_q[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEARCH;
      ref_q      <= '0;
      streak     <= '0;
      phase_idx  <= '0;
      onehot_ok  <= 1'b0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      rot_count  <= '0;
      step_err   <= 1'b0;
    end else begin
      wrap_pulse <= wrap_ev;
      step_err   <= step_ev;
      if (en) begin
        phase_idx <= s_idx;
        onehot_ok <= s_onehot;
        if (s_onehot) ref_q <= phase_in;
        if (wrap_ev) rot_count <= rot_count + 1'b1;
        case (state)
          SEARCH: begin
            if (s_onehot) begin
              state  <= ACQUIRE;
              streak <= '0;
            end
          end
          ACQUIRE: begin
            if (!s_onehot) begin
              state  <= SEARCH;
              streak <= '0;
            end else if (is_adv) begin
              if (streak == STREAK_W'(LOCK_CYCLES - 1)) begin
                state  <= LOCKED;
                locked <= 1'b1;
                streak <= '0;
              end else begin
                streak <= streak + 1'b1;
              end
            end else if (!is_hold) begin
              streak <= '0;
            end
          end
          LOCKED: begin
            if (!legal) begin
              state  <= s_onehot ? ACQUIRE : SEARCH;
              locked <= 1'b0;
              streak <= '0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
            streak <= '0;
          end
        endcase
      end
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
    end else if (step_ev) begin
      err_sticky <= 1'b1;
    end else if (clr_err) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef RING_TRACK_ERRCNT_EN
  // Clear wins here, but an error arriving with the clear still counts as the first one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= step_ev ? 8'd1 : 8'd0;
    end else if (step_ev && (err_count != 8'hFF)) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule
